// File: rtl/conv_host_ctrl.sv
// Host-side sequencer for the binary 3x3 convolution accelerator: loads an image batch,
// writes terminator and weight, runs the accelerator, then streams result rows back.
module conv_host_ctrl #(
  parameter int ADDR_W = 12,
  parameter int MAX_IN = 4094
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic [8:0]        weight,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  input  logic              in_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [15:0]       res_data,
  output logic              res_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              isram_we,
  output logic [ADDR_W-1:0] isram_addr,
  output logic [15:0]       isram_wdata,
  output logic              wmem_we,
  output logic [ADDR_W-1:0] wmem_addr,
  output logic [15:0]       wmem_wdata,
  output logic [ADDR_W-1:0] osram_addr,
  input  logic [15:0]       osram_rdata,
  output logic              dut_run,
  input  logic              dut_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_TERM  = 3'd2;
  localparam logic [2:0] S_WGT   = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [1:0] P_LAT  = 2'd0;
  localparam logic [1:0] P_CAP  = 2'd1;
  localparam logic [1:0] P_HOLD = 2'd2;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_TWO  = {{(ADDR_W-2){1'b0}}, 2'b10};
  localparam logic [ADDR_W-1:0] MAX_ADDR  = ADDR_W'(MAX_IN);
  localparam logic [15:0]       TERM_WORD = 16'h00FF;

  function automatic logic dim_ok(input logic [15:0] d);
    return (d == 16'd10) || (d == 16'd12) || (d == 16'd16);
  endfunction

  logic [2:0]        state_r;
  logic [1:0]        phase_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [ADDR_W-1:0] nrows_r;
  logic [ADDR_W-1:0] rd_idx_r;
  logic [4:0]        rows_left_r;
  logic [1:0]        wait_cnt_r;
  logic              seen_rise_r;
  logic [8:0]        weight_r;
  logic              in_ready_r, res_valid_r, res_last_r, busy_r, done_r, err_r;
  logic              isram_we_r, wmem_we_r, dut_run_r;
  logic [15:0]       res_data_r, isram_wdata_r, wmem_wdata_r;
  logic [ADDR_W-1:0] isram_addr_r, wmem_addr_r, osram_addr_r;

  logic accept_s;
  logic hdr_phase_s;
  logic word_err_s;

  // Classify the word on the input port; a header is expected whenever no rows are pending.
  always_comb begin
    accept_s    = 1'b0;
    hdr_phase_s = (rows_left_r == 5'd0);
    word_err_s  = 1'b0;
    if ((state_r == S_LOAD) && in_ready_r && in_valid) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    if (waddr_r > MAX_ADDR) begin
      word_err_s = 1'b1;
    end else if (hdr_phase_s) begin
      word_err_s = !dim_ok(in_data) || in_last;
    end else begin
      word_err_s = in_last && (rows_left_r != 5'd1);
    end
  end

  // Sequencer: every output is a register so SRAM and accelerator see clean timing.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_r       <= S_IDLE;
      phase_r       <= P_LAT;
      waddr_r       <= ADDR_ZERO;
      nrows_r       <= ADDR_ZERO;
      rd_idx_r      <= ADDR_ZERO;
      rows_left_r   <= 5'd0;
      wait_cnt_r    <= 2'd0;
      seen_rise_r   <= 1'b0;
      weight_r      <= 9'd0;
      in_ready_r    <= 1'b0;
      res_valid_r   <= 1'b0;
      res_last_r    <= 1'b0;
      res_data_r    <= 16'd0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      isram_we_r    <= 1'b0;
      isram_addr_r  <= ADDR_ZERO;
      isram_wdata_r <= 16'd0;
      wmem_we_r     <= 1'b0;
      wmem_addr_r   <= ADDR_ZERO;
      wmem_wdata_r  <= 16'd0;
      osram_addr_r  <= ADDR_ZERO;
      dut_run_r     <= 1'b0;
    end else begin
      isram_we_r <= 1'b0;
      wmem_we_r  <= 1'b0;
      dut_run_r  <= 1'b0;
      done_r     <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            busy_r      <= 1'b1;
            err_r       <= 1'b0;
            waddr_r     <= ADDR_ZERO;
            nrows_r     <= ADDR_ZERO;
            rows_left_r <= 5'd0;
            weight_r    <= weight;
            in_ready_r  <= 1'b1;
            state_r     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept_s) begin
            // Once in error, words are only absorbed until the batch ends.
            if (err_r || word_err_s) begin
              err_r <= 1'b1;
              if (in_last) begin
                in_ready_r <= 1'b0;
                state_r    <= S_DONE;
              end
            end else begin
              isram_we_r    <= 1'b1;
              isram_addr_r  <= waddr_r;
              isram_wdata_r <= in_data;
              waddr_r       <= waddr_r + ADDR_ONE;
              if (hdr_phase_s) begin
                rows_left_r <= in_data[4:0];
                nrows_r     <= nrows_r + {{(ADDR_W-5){1'b0}}, in_data[4:0]} - ADDR_TWO;
              end else begin
                rows_left_r <= rows_left_r - 5'd1;
              end
              if (in_last) begin
                in_ready_r <= 1'b0;
                state_r    <= S_TERM;
              end
            end
          end
        end
        S_TERM: begin
          isram_we_r    <= 1'b1;
          isram_addr_r  <= waddr_r;
          isram_wdata_r <= TERM_WORD;
          state_r       <= S_WGT;
        end
        S_WGT: begin
          wmem_we_r    <= 1'b1;
          wmem_addr_r  <= ADDR_ONE;
          wmem_wdata_r <= {7'd0, weight_r};
          state_r      <= S_RUN;
        end
        S_RUN: begin
          dut_run_r   <= 1'b1;
          wait_cnt_r  <= 2'd0;
          seen_rise_r <= 1'b0;
          state_r     <= S_WAIT;
        end
        S_WAIT: begin
          // The window opens on the cycle dut_run is visible and spans four cycles.
          if (!seen_rise_r) begin
            if (dut_busy) begin
              seen_rise_r <= 1'b1;
            end else if (wait_cnt_r == 2'd3) begin
              err_r   <= 1'b1;
              state_r <= S_DONE;
            end else begin
              wait_cnt_r <= wait_cnt_r + 2'd1;
            end
          end else if (!dut_busy) begin
            if (nrows_r == ADDR_ZERO) begin
              state_r <= S_DONE;
            end else begin
              rd_idx_r     <= ADDR_ZERO;
              osram_addr_r <= ADDR_ZERO;
              phase_r      <= P_LAT;
              state_r      <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          case (phase_r)
            P_LAT: phase_r <= P_CAP;
            P_CAP: begin
              res_data_r  <= osram_rdata;
              res_valid_r <= 1'b1;
              res_last_r  <= (rd_idx_r == nrows_r - ADDR_ONE);
              phase_r     <= P_HOLD;
            end
            P_HOLD: begin
              if (res_ready) begin
                res_valid_r <= 1'b0;
                res_last_r  <= 1'b0;
                if (res_last_r) begin
                  state_r <= S_DONE;
                end else begin
                  rd_idx_r     <= rd_idx_r + ADDR_ONE;
                  osram_addr_r <= rd_idx_r + ADDR_ONE;
                  phase_r      <= P_LAT;
                end
              end
            end
            default: phase_r <= P_LAT;
          endcase
        end
        S_DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign res_valid   = res_valid_r;
  assign res_data    = res_data_r;
  assign res_last    = res_last_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
  assign isram_we    = isram_we_r;
  assign isram_addr  = isram_addr_r;
  assign isram_wdata = isram_wdata_r;
  assign wmem_we     = wmem_we_r;
  assign wmem_addr   = wmem_addr_r;
  assign wmem_wdata  = wmem_wdata_r;
  assign osram_addr  = osram_addr_r;
  assign dut_run     = dut_run_r;

endmodule

// File: tb/tb_conv_host_ctrl.sv
// Bench for conv_host_ctrl: table of batches plus hand-written timeout and reset sequences,
// with behavioural SRAM and accelerator models.
module tb_conv_host_ctrl;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              reset_b;
  logic              start;
  logic [8:0]        weight;
  logic              in_valid, in_ready, in_last;
  logic [15:0]       in_data;
  logic              res_valid, res_ready, res_last;
  logic [15:0]       res_data;
  logic              busy, done, err;
  logic              isram_we, wmem_we, dut_run;
  logic [ADDR_W-1:0] isram_addr, wmem_addr, osram_addr;
  logic [15:0]       isram_wdata, wmem_wdata;
  logic [15:0]       osram_rdata = 16'd0;
  logic              dut_busy = 1'b0;

  conv_host_ctrl #(.ADDR_W(ADDR_W), .MAX_IN(4094)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .weight(weight),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy), .done(done), .err(err),
    .isram_we(isram_we), .isram_addr(isram_addr), .isram_wdata(isram_wdata),
    .wmem_we(wmem_we), .wmem_addr(wmem_addr), .wmem_wdata(wmem_wdata),
    .osram_addr(osram_addr), .osram_rdata(osram_rdata),
    .dut_run(dut_run), .dut_busy(dut_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_mode = 0;
  int acc_cnt = 0;

  function automatic logic [15:0] odata(input logic [ADDR_W-1:0] a);
    return 16'hC300 ^ ({4'd0, a} * 16'd37);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output SRAM with one-cycle read latency.
  always @(posedge clk) osram_rdata <= odata(osram_addr);

  // Accelerator: busy for 50 cycles starting the cycle after dut_run, or never in mode 1.
  always @(posedge clk) begin
    if (dut_run && acc_mode == 0) begin
      dut_busy <= 1'b1;
      acc_cnt  <= 49;
    end else if (acc_cnt != 0) begin
      acc_cnt <= acc_cnt - 1;
    end else begin
      dut_busy <= 1'b0;
    end
  end

  logic [15:0]       imem [0:4095];
  logic [ADDR_W-1:0] last_w_addr = '0;
  logic [ADDR_W-1:0] wmem_last_addr = '0;
  logic [15:0]       wmem_last_data = 16'd0;
  logic [ADDR_W-1:0] oaddr_q = '0;
  logic [15:0]       stall_data = 16'd0;
  logic              stall_q = 1'b0;
  logic              err_q = 1'b0;
  int iwr_cnt = 0, run_cnt = 0, done_cnt = 0, oaddr_chg = 0, stall_viol = 0;
  int last_w_cyc = 0, prev_w_cyc = 0, wmem_cyc = 0, run_cyc = 0, err_cyc = 0;
  logic [16:0] rows_q[$];
  int          hs_q[$];

  // Observe DUT outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (isram_we) begin
      imem[isram_addr] <= isram_wdata;
      iwr_cnt          <= iwr_cnt + 1;
      prev_w_cyc       <= last_w_cyc;
      last_w_cyc       <= cyc;
      last_w_addr      <= isram_addr;
    end
    if (wmem_we) begin
      wmem_last_addr <= wmem_addr;
      wmem_last_data <= wmem_wdata;
      wmem_cyc       <= cyc;
    end
    if (dut_run) begin
      run_cnt <= run_cnt + 1;
      run_cyc <= cyc;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (err && !err_q) err_cyc <= cyc;
    err_q <= err;
    if (osram_addr != oaddr_q) oaddr_chg <= oaddr_chg + 1;
    oaddr_q <= osram_addr;
    if (res_valid && res_ready) begin
      rows_q.push_back({res_last, res_data});
      hs_q.push_back(cyc);
    end
    if (stall_q && (!res_valid || res_data != stall_data)) stall_viol <= stall_viol + 1;
    stall_q    <= res_valid && !res_ready;
    stall_data <= res_data;
  end

  typedef struct {
    logic [15:0] hdr0;
    int          rows0;
    logic [15:0] hdr1;
    int          rows1;
    logic [8:0]  w;
    bit          rnd;
    bit          exp_err;
    int          exp_nrows;
    int          exp_words;
  } vec_t;

  logic [16:0] words_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_image(input logic [15:0] hdr, input int rows, input bit last_img);
    words_q.push_back({1'b0, hdr});
    for (int r = 0; r < rows; r++)
      words_q.push_back({last_img && (r == rows - 1), 16'h1000 + 16'(r) + (hdr << 8)});
  endtask

  task automatic send_words();
    bit acc;
    for (int i = 0; i < words_q.size(); i++) begin
      in_valid = 1'b1;
      {in_last, in_data} = words_q[i];
      acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) begin
        @(negedge clk);
        acc = in_ready;
        tick();
      end
      if (!acc) begin
        chk("load_accept", 64'(acc), 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic start_batch(input logic [8:0] w);
    weight = w;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("in_ready_first_load", 64'(in_ready), 64'd1);
    chk("err_clear_on_start", 64'(err), 64'd0);
  endtask

  task automatic wait_done(input bit rnd);
    int d0 = done_cnt;
    for (int k = 0; k < 3000 && done_cnt == d0; k++) begin
      res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    res_ready = 1'b0;
    chk("done_pulse", 64'(done_cnt - d0), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
  endtask

  task automatic load_batch(input vec_t v);
    words_q.delete();
    add_image(v.hdr0, v.rows0, v.hdr1 == 16'd0);
    if (v.hdr1 != 16'd0) add_image(v.hdr1, v.rows1, 1'b1);
    start_batch(v.w);
    send_words();
    wait_done(v.rnd);
  endtask

  task automatic run_vec(input vec_t v);
    int w0 = iwr_cnt, r0 = run_cnt, q0 = rows_q.size(), h0 = hs_q.size(), o0 = oaddr_chg;
    load_batch(v);
    chk("err", 64'(err), 64'(v.exp_err));
    chk("isram_writes", 64'(iwr_cnt - w0), 64'(v.exp_words));
    chk("runs", 64'(run_cnt - r0), 64'(!v.exp_err));
    if (!v.exp_err) begin
      chk("term_addr", 64'(last_w_addr), 64'(v.exp_words - 1));
      chk("term_data", 64'(imem[v.exp_words - 1]), 64'h00FF);
      chk("hdr0_data", 64'(imem[0]), 64'(v.hdr0));
      chk("wmem_addr", 64'(wmem_last_addr), 64'd1);
      chk("wmem_data", 64'(wmem_last_data), 64'({7'd0, v.w}));
      chk("term_after_data", 64'(last_w_cyc - prev_w_cyc), 64'd1);
      chk("wgt_after_term", 64'(wmem_cyc - last_w_cyc), 64'd1);
      chk("run_after_wgt", 64'(run_cyc - wmem_cyc), 64'd1);
      chk("row_count", 64'(rows_q.size() - q0), 64'(v.exp_nrows));
      for (int i = 0; i < v.exp_nrows && q0 + i < rows_q.size(); i++) begin
        chk("row_data", 64'(rows_q[q0 + i][15:0]), 64'(odata(ADDR_W'(i))));
        chk("row_last", 64'(rows_q[q0 + i][16]), 64'(i == v.exp_nrows - 1));
      end
      if (!v.rnd)
        for (int i = h0 + 1; i < hs_q.size(); i++)
          chk("row_spacing", 64'(hs_q[i] - hs_q[i - 1]), 64'd3);
    end else begin
      chk("no_reads", 64'(oaddr_chg - o0), 64'd0);
      chk("no_results", 64'(rows_q.size() - q0), 64'd0);
    end
  endtask

  initial begin
    vec_t vecs[6];
    int w0, r0, q0;
    vecs[0] = '{16'd10, 10, 16'd0,  0,  9'h1FF, 1'b0, 1'b0, 8,  12};
    vecs[1] = '{16'd16, 16, 16'd12, 12, 9'h0A5, 1'b1, 1'b0, 24, 31};
    vecs[2] = '{16'd12, 12, 16'd0,  0,  9'h000, 1'b0, 1'b0, 10, 14};
    vecs[3] = '{16'd14, 14, 16'd0,  0,  9'h1FF, 1'b0, 1'b1, 0,  0};
    vecs[4] = '{16'd12, 5,  16'd0,  0,  9'h1FF, 1'b0, 1'b1, 0,  5};
    vecs[5] = '{16'd10, 10, 16'd16, 16, 9'h155, 1'b1, 1'b0, 22, 29};

    reset_b = 1'b0; start = 1'b0; weight = 9'd0;
    in_valid = 1'b0; in_data = 16'd0; in_last = 1'b0; res_ready = 1'b0;
    repeat (3) tick();
    reset_b = 1'b1;
    tick();
    chk("rst_ctrl", 64'({in_ready, res_valid, res_last, busy, done, err, isram_we, wmem_we, dut_run}), 64'd0);
    chk("rst_addr", 64'({isram_addr, wmem_addr, osram_addr}), 64'd0);
    chk("rst_data", 64'({isram_wdata, wmem_wdata, res_data}), 64'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Accelerator never answers dut_run.
    acc_mode = 1;
    r0 = run_cnt;
    q0 = rows_q.size();
    load_batch(vecs[0]);
    chk("timeout_err", 64'(err), 64'd1);
    chk("timeout_gap", 64'(err_cyc - run_cyc), 64'd4);
    chk("timeout_runs", 64'(run_cnt - r0), 64'd1);
    chk("timeout_no_results", 64'(rows_q.size() - q0), 64'd0);
    acc_mode = 0;
    run_vec(vecs[0]);

    // Reset in the middle of LOAD, right after the fifth word is accepted.
    words_q.delete();
    add_image(16'd12, 4, 1'b0);
    start_batch(9'h0F0);
    send_words();
    reset_b = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({in_ready, res_valid, res_last, busy, done, err, isram_we, wmem_we, dut_run}), 64'd0);
    chk("midrst_addr", 64'({isram_addr, wmem_addr, osram_addr}), 64'd0);
    w0 = iwr_cnt;
    repeat (3) tick();
    reset_b = 1'b1;
    repeat (10) tick();
    chk("no_write_after_reset", 64'(iwr_cnt - w0), 64'd0);
    chk("idle_after_reset", 64'({busy, in_ready}), 64'd0);
    run_vec(vecs[2]);

    chk("stall_stable", 64'(stall_viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/conv_host_ctrl.md
# conv_host_ctrl

Host-side sequencer for the binary 3x3 convolution accelerator. It loads a batch of images from a valid/ready stream into the input SRAM, terminates the batch, and writes the 9-bit weight to weight-SRAM address 1. It then starts the accelerator with `dut_run` and waits on `dut_busy`. When the accelerator finishes, it reads the output SRAM and streams the result rows back to the host. It is the driving and consuming end of the accelerator's run/busy and SRAM data protocol.

## Interface
- `ADDR_W`, 12: SRAM address width.
- `MAX_IN`, 4094: highest input-SRAM address usable for image data. Address `MAX_IN+1` is reserved for the terminator.
- `clk` in 1: single clock, all logic on rising edge.
- `reset_b` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a batch. Honoured only in IDLE.
- `weight` in 9: kernel bits, sampled on the cycle `start` is accepted.
- `in_valid` / `in_ready` in/out 1: image word handshake.
- `in_data` in 16: image word, header or row.
- `in_last` in 1: marks the final word of the batch.
- `res_valid` / `res_ready` out/in 1: result handshake.
- `res_data` out 16: result row.
- `res_last` out 1: marks the final result row.
- `busy` out 1: high from start acceptance to `done`.
- `done` out 1: one-cycle pulse at batch end.
- `err` out 1: sticky error, cleared by the next accepted `start`.
- `isram_we` out 1, `isram_addr` out ADDR_W, `isram_wdata` out 16: input-SRAM write port.
- `wmem_we` out 1, `wmem_addr` out ADDR_W, `wmem_wdata` out 16: weight-SRAM write port.
- `osram_addr` out ADDR_W, `osram_rdata` in 16: output-SRAM read port, one-cycle read latency.
- `dut_run` out 1, `dut_busy` in 1: accelerator control.

## Operation
- **States:** IDLE, LOAD, TERM, WGT, RUN, WAIT, DRAIN, DONE.
- **IDLE → LOAD** on `start`. This clears `err`, the input write address, and the output-row count `nrows`.
- **LOAD:** `in_ready`=1.
  - Words alternate between a header and `dim` rows, repeating per image.
  - A header must be 10, 12 or 16. On each valid header, `nrows += dim-2`.
  - Each accepted word is written to the input SRAM at sequential addresses from 0.
- **LOAD → TERM** when the accepted word has `in_last`=1.
- **Error inside LOAD:**
  - Triggers: an invalid header, `in_last` arriving before the current image's rows are complete, or a write to an address above `MAX_IN`.
  - Response: set `err`, stop writing, keep `in_ready`=1 and discard words until `in_last`, then go to DONE (skipping RUN).
- **TERM:** write 16'h00FF at the next address, then go to WGT.
- **WGT:** write {7'd0, weight} to `wmem_addr`=1, then go to RUN.
- **RUN:** `dut_run`=1 for exactly one cycle, then go to WAIT.
- **WAIT:** wait for `dut_busy` to rise and then fall. A rise must occur within 4 cycles of `dut_run`; otherwise set `err` and go to DONE. A fall means go to DRAIN.
- **DRAIN:** read output addresses 0..`nrows`-1 in order.
  - Only one read is outstanding at a time. The data is held in `res_data` with `res_valid`=1 until `res_ready`.
  - `res_last`=1 on row `nrows`-1.
  - After the last handshake, go to DONE.
- **DONE:** `done`=1 for one cycle, `busy`=0, return to IDLE.
- **Data rules:** `nrows` is 12 bits with no wrap, bounded by the address check. Result data is passed through unmodified.
- **Reset:** asserted mid-operation, it aborts immediately. No further SRAM writes are issued.

## Timing
- **Reset values:** all outputs 0, including `in_ready`, `res_valid`, all write enables, `dut_run`, `busy`, `done`, `err` and all addresses. State is IDLE.
- **`start`:** `busy` rises the cycle after `start`. `in_ready` is high from the first LOAD cycle.
- **Input writes:** an accepted word at cycle t produces `isram_we`=1 with registered address and data at t+1. One write per accepted word, with a throughput of 1 word per cycle.
- **Terminator and weight:** the terminator write occurs 1 cycle after the last data write, and the weight write 1 cycle after that. `dut_run` is asserted the next cycle.
- **Drain reads:** `osram_addr` is issued at cycle t, and `res_valid` rises at t+2 (data registered). The next address is issued the cycle after a handshake. Best-case throughput is 1 row per 3 cycles.
- **`start` outside IDLE** is ignored.
- **`res_valid` with `res_ready` low:** `res_valid` must not drop and `res_data` must not change until the handshake completes.

## Test plan
- **Single 10x10 image:** start with weight=9'h1FF; stream header 10 and 10 rows with `in_last` on the final row.
  - Input SRAM: addresses 0..10 written, address 11 = 00FF.
  - Weight SRAM: address 1 = 01FF.
  - One `dut_run` pulse; the bench model busies for 50 cycles.
  - 8 result rows from output addresses 0..7, `res_last` on the 8th, then `done`.
- **Batch of 16 + 12 images:** `nrows`=24, terminator at address 30, 24 results streamed. `res_ready` is toggled randomly, and `res_data` must be stable while stalled.
- **Invalid header 14:** `err`=1, remaining words are absorbed until `in_last`, no `dut_run`, `done` pulses, and no output reads are issued.
- **Premature `in_last`:** header 12 followed by only 5 rows with `in_last` → `err`=1, no run.
- **Accelerator never raises busy:** `err` is set 4 cycles after `dut_run`, then `done`. A subsequent `start` clears `err`.
- **Reset during LOAD:** assert `reset_b`=0 after word 5 → all outputs 0 on the next edge, state IDLE, and no SRAM write after reset.
